// File: rtl/adder_selftest_pkg.sv
// Shared types and constants for the adder self-test driver: FSM states,
// LFSR polynomial, B-seed mask and the directed carry-chain vectors.
package adder_selftest_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } operands_t;

   localparam logic [31:0] LfsrPoly  = 32'h8020_0003;
   localparam logic [31:0] BSeedMask = 32'hA5A5_A5A5;

   localparam operands_t DirVec0 = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001};
   localparam operands_t DirVec1 = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
   localparam operands_t DirVec2 = '{a: 32'h0000_0000, b: 32'h0000_0000};

endpackage

// File: rtl/adder_selftest_driver_if.sv
// Operand/result bus between the self-test driver (master) and the adder
// wrapper under test (slave).
interface adder_selftest_driver_if;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [31:0] sum_in;
   logic        cout_in;

   modport master (output a_out, output b_out, input sum_in, input cout_in);
   modport slave  (input a_out, input b_out, output sum_in, output cout_in);
endinterface

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR; a zero load value is replaced by 1 so
// the register can never lock up in the all-zero state.
module lfsr32_galois
   import adder_selftest_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= 32'h1;
      end else if (load) begin
         state <= (load_val == 32'h0) ? 32'h1 : load_val;
      end else if (step) begin
         state <= {1'b0, state[31:1]} ^ (state[0] ? LfsrPoly : 32'h0);
      end
   end

endmodule

// File: rtl/adder_selftest_driver.sv
// Drives directed then LFSR operand pairs into a registered 32-bit adder and
// checks its sum/cout against a delayed golden add, giving pass/fail and counts.
module adder_selftest_driver
   import adder_selftest_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_vectors,
   input  logic [31:0]          seed,
   adder_selftest_driver_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     first_err_idx
);

   localparam int unsigned DrainW = $clog2(LATENCY + 1);

   state_e              state;
   logic [CNT_W-1:0]    vec_idx;
   logic [CNT_W-1:0]    num_vec_q;
   logic [DrainW-1:0]   drain_cnt;
   logic                iss_valid;
   logic [CNT_W-1:0]    iss_idx;

   logic [LATENCY-1:0]             dl_valid;
   logic [LATENCY-1:0][CNT_W-1:0]  dl_idx;
   logic [LATENCY-1:0][32:0]       dl_exp;

   logic [31:0]      lfsr_a;
   logic [31:0]      lfsr_b;
   logic             accept;
   logic             lfsr_step;
   operands_t        vec;
   logic             mismatch;
   logic [CNT_W-1:0] err_sat;

   assign accept    = start && ((state == StIdle) || (state == StDone));
   assign lfsr_step = (state == StRun) && (vec_idx >= CNT_W'(3));

   lfsr32_galois u_lfsr_a (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (seed),
      .step     (lfsr_step),
      .state    (lfsr_a)
   );

   lfsr32_galois u_lfsr_b (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (seed ^ BSeedMask),
      .step     (lfsr_step),
      .state    (lfsr_b)
   );

   always_comb begin
      vec = '{a: lfsr_a, b: lfsr_b};
      if (vec_idx == CNT_W'(0)) begin
         vec = DirVec0;
      end else if (vec_idx == CNT_W'(1)) begin
         vec = DirVec1;
      end else if (vec_idx == CNT_W'(2)) begin
         vec = DirVec2;
      end
   end

   // Delay-line tail lines up with the wrapper result for the same vector.
   assign mismatch = dl_valid[LATENCY-1] &&
                     ({bus.cout_in, bus.sum_in} != dl_exp[LATENCY-1]);
   assign err_sat  = (err_count == '1) ? err_count : err_count + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         vec_idx       <= '0;
         num_vec_q     <= '0;
         drain_cnt     <= '0;
         iss_valid     <= 1'b0;
         iss_idx       <= '0;
         dl_valid      <= '0;
         dl_idx        <= '0;
         dl_exp        <= '0;
         bus.a_out     <= 32'h0;
         bus.b_out     <= 32'h0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '1;
      end else begin
         for (int i = int'(LATENCY) - 1; i > 0; i--) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_idx[i]   <= dl_idx[i-1];
            dl_exp[i]   <= dl_exp[i-1];
         end
         dl_valid[0] <= iss_valid;
         dl_idx[0]   <= iss_idx;
         dl_exp[0]   <= {1'b0, bus.a_out} + {1'b0, bus.b_out};

         if (mismatch) begin
            err_count <= err_sat;
            if (err_count == '0) begin
               first_err_idx <= dl_idx[LATENCY-1];
            end
         end

         iss_valid <= 1'b0;
         bus.a_out <= 32'h0;
         bus.b_out <= 32'h0;

         case (state)
            StIdle, StDone: begin
               if (start) begin
                  num_vec_q     <= num_vectors;
                  vec_idx       <= '0;
                  err_count     <= '0;
                  first_err_idx <= '1;
                  if (num_vectors == '0) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= StRun;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            StRun: begin
               bus.a_out <= vec.a;
               bus.b_out <= vec.b;
               iss_valid <= 1'b1;
               iss_idx   <= vec_idx;
               vec_idx   <= vec_idx + CNT_W'(1);
               if (vec_idx == num_vec_q - CNT_W'(1)) begin
                  state     <= StDrain;
                  drain_cnt <= '0;
               end
            end
            StDrain: begin
               // Last compare lands on the same edge that enters DONE.
               if (drain_cnt == DrainW'(LATENCY)) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  drain_cnt <= drain_cnt + DrainW'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
